// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: hall state encodings, commutation-order lookups and
// the decoder tracking-state encoding.
package bldc_pkg;

  localparam logic [2:0] HALL_001 = 3'b001;
  localparam logic [2:0] HALL_011 = 3'b011;
  localparam logic [2:0] HALL_010 = 3'b010;
  localparam logic [2:0] HALL_110 = 3'b110;
  localparam logic [2:0] HALL_100 = 3'b100;
  localparam logic [2:0] HALL_101 = 3'b101;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_TRACK,
    ST_FAULT
  } hall_state_e;

  function automatic logic is_illegal(input logic [2:0] h);
    return (h == 3'b000) || (h == 3'b111);
  endfunction

  // Illegal inputs map to 000 so they never match a real neighbour.
  function automatic logic [2:0] next_fwd(input logic [2:0] h);
    case (h)
      HALL_001: next_fwd = HALL_011;
      HALL_011: next_fwd = HALL_010;
      HALL_010: next_fwd = HALL_110;
      HALL_110: next_fwd = HALL_100;
      HALL_100: next_fwd = HALL_101;
      HALL_101: next_fwd = HALL_001;
      default:  next_fwd = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] next_rev(input logic [2:0] h);
    case (h)
      HALL_001: next_rev = HALL_101;
      HALL_101: next_rev = HALL_100;
      HALL_100: next_rev = HALL_110;
      HALL_110: next_rev = HALL_010;
      HALL_010: next_rev = HALL_011;
      HALL_011: next_rev = HALL_001;
      default:  next_rev = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Two-flop synchroniser plus stability filter for the 3-bit hall vector;
// emits the accepted vector and a one-cycle pulse when it changes.
module hall_glitch_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] raw,
  output logic [2:0] hall,
  output logic       edge_valid
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    prev;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // cnt is the number of whole cycles sync2 has held its current value,
  // saturating at FILTER_LEN.
  always_comb begin
    cnt_next = cnt;
    if (sync2 != prev)
      cnt_next = CW'(1);
    else if (cnt != CW'(FILTER_LEN))
      cnt_next = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      cnt        <= '0;
      hall       <= '0;
      edge_valid <= 1'b0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      prev       <= sync2;
      cnt        <= cnt_next;
      edge_valid <= 1'b0;
      if ((cnt_next == CW'(FILTER_LEN)) && (sync2 != hall)) begin
        hall       <= sync2;
        edge_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hall_sensor_decoder.sv
// Hall sensor front-end: filtered hall lines, direction, step period,
// stall and sequence-error detection for the commutation and speed loops.
module hall_sensor_decoder
  import bldc_pkg::*;
#(
  parameter int unsigned REG_SIZE   = 16,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                hall_a_raw,
  input  logic                hall_b_raw,
  input  logic                hall_c_raw,
  output logic                hall_1,
  output logic                hall_2,
  output logic                hall_3,
  output logic                edge_valid,
  output logic                direction,
  output logic [REG_SIZE-1:0] period,
  output logic                period_valid,
  output logic                stall,
  output logic                seq_error
);

  localparam logic [REG_SIZE-1:0] CNT_MAX = '1;

  logic [2:0]          hall_vec;
  logic [2:0]          last_hall;
  logic [REG_SIZE-1:0] cnt;
  hall_state_e         state;

  hall_glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk        (clk),
    .rst        (rst),
    .raw        ({hall_a_raw, hall_b_raw, hall_c_raw}),
    .hall       (hall_vec),
    .edge_valid (edge_valid)
  );

  assign hall_1 = hall_vec[2];
  assign hall_2 = hall_vec[1];
  assign hall_3 = hall_vec[0];

  // Tracking reacts to the registered edge_valid, so direction/period/flags
  // follow the hall outputs by one clock; edge-to-edge spacing is unaffected.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      last_hall    <= '0;
      cnt          <= '0;
      direction    <= 1'b1;
      period       <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b0;
      seq_error    <= 1'b0;
    end else if (!enable) begin
      state        <= ST_INIT;
      cnt          <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b0;
      seq_error    <= edge_valid && is_illegal(hall_vec);
      if (edge_valid)
        last_hall <= hall_vec;
    end else begin
      seq_error <= 1'b0;
      if (edge_valid) begin
        cnt       <= REG_SIZE'(1);
        stall     <= 1'b0;
        last_hall <= hall_vec;
        if (is_illegal(hall_vec)) begin
          seq_error    <= 1'b1;
          period_valid <= 1'b0;
          state        <= ST_FAULT;
        end else begin
          case (state)
            ST_TRACK: begin
              if (hall_vec == next_fwd(last_hall)) begin
                direction    <= 1'b1;
                period       <= cnt;
                period_valid <= 1'b1;
              end else if (hall_vec == next_rev(last_hall)) begin
                direction    <= 1'b0;
                period       <= cnt;
                period_valid <= 1'b1;
              end else begin
                seq_error    <= 1'b1;
                period_valid <= 1'b0;
                state        <= ST_INIT;
              end
            end
            default: begin
              period_valid <= 1'b0;
              state        <= ST_TRACK;
            end
          endcase
        end
      end else begin
        if (cnt != CNT_MAX)
          cnt <= cnt + REG_SIZE'(1);
        if (cnt >= CNT_MAX - REG_SIZE'(1)) begin
          stall        <= 1'b1;
          period_valid <= 1'b0;
          state        <= ST_INIT;
        end
      end
    end
  end

endmodule
